count_checker: RTL and testbench
================================

COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4, giving the width of the observed counter.
REQ-002 The module SHALL have parameter ERRW, default 8, giving the width of the error counter.
REQ-003 Port clk SHALL be input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst_n SHALL be input, 1 bit: synchronous, active-low reset.
REQ-005 Port obs_rst SHALL be input, 1 bit: the observed counter's active-high synchronous reset.
REQ-006 Port obs_load SHALL be input, 1 bit: the observed counter's load enable.
REQ-007 Port obs_updown SHALL be input, 1 bit: the observed counter's direction; 1 = up, 0 = down.
REQ-008 Port obs_d SHALL be input, WIDTH bits: the observed counter's load value.
REQ-009 Port obs_count SHALL be input, WIDTH bits: the observed counter's output.
REQ-010 Port synced SHALL be output, 1 bit: the reference model is aligned and checking is active.
REQ-011 Port err SHALL be output, 1 bit: a one-cycle pulse on each mismatch.
REQ-012 Port err_sticky SHALL be output, 1 bit: set by the first mismatch, held until reset.
REQ-013 Port err_cnt SHALL be output, ERRW bits: a saturating count of mismatches.
REQ-014 Port exp_count SHALL be output, WIDTH bits: the current model value, for debug.

Function
REQ-015 The model SHALL update every clk edge with this priority: obs_rst gives 0; else obs_load gives obs_d; else obs_updown=1 gives exp+1, else exp-1.
REQ-016 Model arithmetic SHALL wrap modulo 2^WIDTH: 1111 up gives 0000, and 0000 down gives 1111.
REQ-017 The FSM SHALL have exactly two states, UNSYNC and TRACK.
REQ-018 UNSYNC SHALL move to TRACK on a clk edge where obs_rst=1 or obs_load=1, since the model value is then known.
REQ-019 There SHALL be no path from TRACK back to UNSYNC except rst_n.
REQ-020 synced SHALL be 1 exactly when the state is TRACK.
REQ-021 In TRACK, each cycle SHALL compare obs_count with exp_count combinationally; a mismatch is registered, so err asserts on the next edge for exactly 1 cycle.
REQ-022 In UNSYNC, no comparison SHALL occur: err stays 0 and err_cnt is unchanged.
REQ-023 err_cnt SHALL increment by 1 per mismatch and saturate at 2^ERRW-1 without wrapping.
REQ-024 Simultaneous obs_rst and obs_load SHALL give model value 0 (obs_rst wins).
REQ-025 Comparison in the cycle the FSM enters TRACK SHALL use the newly aligned model value.

Reset
REQ-026 With rst_n=0 at a clk edge, the block SHALL set state UNSYNC, exp_count 0, err 0, err_sticky 0, err_cnt 0, synced 0.
REQ-027 Reset SHALL win over every other input, including asserted obs_rst or obs_load.
REQ-028 Reset mid-TRACK SHALL discard all history; after rst_n=1 the block resynchronises per REQ-018.

Configuration
REQ-029 With macro COUNT_CHECKER_RESYNC_EN defined, each mismatch SHALL load exp_count from obs_count+1 or obs_count-1 (per obs_updown, and honoring obs_rst/obs_load priority), so one fault gives one err pulse.
REQ-030 Without COUNT_CHECKER_RESYNC_EN, the model SHALL ignore obs_count, so a persistent offset gives an err pulse every cycle.

Structure
REQ-031 Shared package count_chk_pkg SHALL hold the state enum (UNSYNC, TRACK) and the default WIDTH and ERRW constants.
REQ-032 Sub-module count_model SHALL contain the expected-value register and the next-value logic; the FSM and error logic SHALL stay in the top module.

Verification
REQ-033 Scenario: rst_n low then high, obs_rst=0 and obs_load=0 for 5 cycles, random obs_count -> synced=0, err never 1, err_cnt=0.
REQ-034 Scenario: obs_rst=1 for 1 cycle, then up-count with a correct counter from 0 through 15 to 0 -> synced=1, wrap accepted, err_cnt=0.
REQ-035 Scenario: obs_load=1 with obs_d=1001, then down-count to 1000, 0111 -> no error; then force obs_count=0000 where 0110 is expected -> err pulses 1 cycle, err_sticky=1, err_cnt=1.
REQ-036 Scenario: persistent +1 offset for 3 cycles -> err_cnt=3 without COUNT_CHECKER_RESYNC_EN, err_cnt=1 with it.
REQ-037 Scenario: obs_rst=1 and obs_load=1 (obs_d=0101) in the same cycle -> exp_count=0, and obs_count=0 gives no error.
REQ-038 Scenario: ERRW=2 with 5 mismatches -> err_cnt saturates at 3; then rst_n low for 1 cycle -> all outputs 0, synced=0.

Source files
------------

// File: rtl/count_chk_pkg.sv
// Shared definitions for the counter checker: tracking-FSM states and default widths.
package count_chk_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_ERRW  = 8;

  typedef enum logic [0:0] {
    UNSYNC = 1'b0,
    TRACK  = 1'b1
  } state_t;

endpackage

// File: rtl/count_model.sv
// Reference model of the observed up/down counter: expected-value register plus next-value logic.
// When resync is high the next value is derived from the observed count instead of the model.
module count_model
  import count_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             obs_rst,
  input  logic             obs_load,
  input  logic             obs_updown,
  input  logic [WIDTH-1:0] obs_d,
  input  logic [WIDTH-1:0] obs_count,
  input  logic             resync,
  output logic [WIDTH-1:0] exp_count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] base_p0;
  logic [WIDTH-1:0] exp_next_p0;
  logic [WIDTH-1:0] exp_p1;

  // Stage p0: choose the value to step from, then apply rst > load > up/down priority
  always_comb begin
    base_p0 = resync ? obs_count : exp_p1;
    if (obs_rst) begin
      exp_next_p0 = '0;
    end else if (obs_load) begin
      exp_next_p0 = obs_d;
    end else if (obs_updown) begin
      exp_next_p0 = base_p0 + ONE;
    end else begin
      exp_next_p0 = base_p0 - ONE;
    end
  end

  // Stage p1: expected-value register, wraps naturally modulo 2^WIDTH
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exp_p1 <= '0;
    end else begin
      exp_p1 <= exp_next_p0;
    end
  end

  assign exp_count = exp_p1;

endmodule

// File: rtl/count_checker.sv
// Online checker for an up/down counter with sync reset and load; flags cycles where it diverges.
// Optional macro COUNT_CHECKER_RESYNC_EN realigns the model to the observed count after a mismatch.
module count_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ERRW  = DEF_ERRW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             obs_rst,
  input  logic             obs_load,
  input  logic             obs_updown,
  input  logic [WIDTH-1:0] obs_d,
  input  logic [WIDTH-1:0] obs_count,
  output logic             synced,
  output logic             err,
  output logic             err_sticky,
  output logic [ERRW-1:0]  err_cnt,
  output logic [WIDTH-1:0] exp_count
);

  state_t            state;
  logic              mismatch_p0;
  logic              resync;
  logic              err_p1;
  logic              sticky_p1;
  logic [ERRW-1:0]   cnt_p1;

  function automatic logic [ERRW-1:0] sat_inc(input logic [ERRW-1:0] v);
    sat_inc = (&v) ? v : v + ERRW'(1);
  endfunction

  count_model #(
    .WIDTH(WIDTH)
  ) u_model (
    .clk        (clk),
    .rst_n      (rst_n),
    .obs_rst    (obs_rst),
    .obs_load   (obs_load),
    .obs_updown (obs_updown),
    .obs_d      (obs_d),
    .obs_count  (obs_count),
    .resync     (resync),
    .exp_count  (exp_count)
  );

  // Stage p0: compare only once the model value is known
  assign mismatch_p0 = (state == TRACK) && (obs_count != exp_count);

`ifdef COUNT_CHECKER_RESYNC_EN
  assign resync = mismatch_p0;
`else
  assign resync = 1'b0;
`endif

  // Any reset or load of the observed counter pins down its value; only rst_n leaves TRACK
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= UNSYNC;
    end else if ((state == UNSYNC) && (obs_rst || obs_load)) begin
      state <= TRACK;
    end
  end

  // Stage p1: registered error pulse, sticky flag and saturating counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_p1    <= 1'b0;
      sticky_p1 <= 1'b0;
      cnt_p1    <= '0;
    end else begin
      err_p1 <= mismatch_p0;
      if (mismatch_p0) begin
        sticky_p1 <= 1'b1;
        cnt_p1    <= sat_inc(cnt_p1);
      end
    end
  end

  assign synced     = (state == TRACK);
  assign err        = err_p1;
  assign err_sticky = sticky_p1;
  assign err_cnt    = cnt_p1;

endmodule

// File: tb/tb_count_checker.sv
// Scoreboard bench for count_checker: two instances (ERRW=8 and ERRW=2) share one stimulus stream.
module tb_count_checker;

`ifdef COUNT_CHECKER_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       obs_rst = 1'b0;
  logic       obs_load = 1'b0;
  logic       obs_updown = 1'b0;
  logic [3:0] obs_d = 4'd0;
  logic [3:0] obs_count = 4'd0;

  logic       synced8, err8, sticky8;
  logic [7:0] cnt8;
  logic [3:0] exp8;
  logic       synced2, err2, sticky2;
  logic [1:0] cnt2;
  logic [3:0] exp2;

  always #5 clk = ~clk;

  count_checker #(.WIDTH(4), .ERRW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .obs_rst(obs_rst), .obs_load(obs_load),
    .obs_updown(obs_updown), .obs_d(obs_d), .obs_count(obs_count),
    .synced(synced8), .err(err8), .err_sticky(sticky8), .err_cnt(cnt8),
    .exp_count(exp8)
  );

  count_checker #(.WIDTH(4), .ERRW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .obs_rst(obs_rst), .obs_load(obs_load),
    .obs_updown(obs_updown), .obs_d(obs_d), .obs_count(obs_count),
    .synced(synced2), .err(err2), .err_sticky(sticky2), .err_cnt(cnt2),
    .exp_count(exp2)
  );

  typedef struct {
    int synced, err, sticky, cnt8, cnt2, expc;
    int hs, he, hst, hc8, hc2, hx;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  bit       m_sync = 1'b0;
  bit       m_err = 1'b0;
  bit       m_sticky = 1'b0;
  logic [3:0] m_exp = 4'd0;
  int       m_cnt8 = 0;
  int       m_cnt2 = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model prediction for the post-edge outputs is queued
  task automatic step(input logic r_n, input logic orst, input logic ld,
                      input logic up, input logic [3:0] d, input logic [3:0] cnt);
    exp_t e;
    bit mis;
    logic [3:0] b;
    rst_n = r_n; obs_rst = orst; obs_load = ld; obs_updown = up;
    obs_d = d; obs_count = cnt;
    @(posedge clk);
    #1;
    mis = m_sync && (cnt != m_exp);
    if (!r_n) begin
      m_sync = 0; m_err = 0; m_sticky = 0; m_exp = 4'd0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      b = (RESYNC && mis) ? cnt : m_exp;
      if (orst)      m_exp = 4'd0;
      else if (ld)   m_exp = d;
      else if (up)   m_exp = 4'((int'(b) + 1) % 16);
      else           m_exp = 4'((int'(b) + 15) % 16);
      m_sync = m_sync || orst || ld;
      m_err = mis;
      if (mis) begin
        m_sticky = 1'b1;
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3)   m_cnt2++;
      end
    end
    e.synced = int'(m_sync); e.err = int'(m_err); e.sticky = int'(m_sticky);
    e.cnt8 = m_cnt8; e.cnt2 = m_cnt2; e.expc = int'(m_exp);
    e.hs = -1; e.he = -1; e.hst = -1; e.hc8 = -1; e.hc2 = -1; e.hx = -1;
    q.push_back(e);
  endtask

  // Attach hand-computed values to the most recent expectation (-1 = don't care)
  task automatic hand(input int hs, input int he, input int hst,
                      input int hc8, input int hc2, input int hx);
    q[q.size()-1].hs  = hs;
    q[q.size()-1].he  = he;
    q[q.size()-1].hst = hst;
    q[q.size()-1].hc8 = hc8;
    q[q.size()-1].hc2 = hc2;
    q[q.size()-1].hx  = hx;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("synced8", int'(synced8), e.synced);
        chk("synced2", int'(synced2), e.synced);
        chk("err8", int'(err8), e.err);
        chk("err2", int'(err2), e.err);
        chk("sticky8", int'(sticky8), e.sticky);
        chk("sticky2", int'(sticky2), e.sticky);
        chk("err_cnt8", int'(cnt8), e.cnt8);
        chk("err_cnt2", int'(cnt2), e.cnt2);
        chk("exp_count8", int'(exp8), e.expc);
        chk("exp_count2", int'(exp2), e.expc);
        if (e.hs >= 0)  chk("hand_synced", int'(synced8), e.hs);
        if (e.he >= 0)  chk("hand_err", int'(err8), e.he);
        if (e.hst >= 0) chk("hand_sticky", int'(sticky8), e.hst);
        if (e.hc8 >= 0) chk("hand_err_cnt8", int'(cnt8), e.hc8);
        if (e.hc2 >= 0) chk("hand_err_cnt2", int'(cnt2), e.hc2);
        if (e.hx >= 0)  chk("hand_exp_count", int'(exp8), e.hx);
      end
    end
  end

  initial begin : stimulus
    int c;
    // Reset, including reset winning over obs_rst/obs_load
    step(0, 0, 0, 0, 4'd0, 4'd0);
    step(0, 0, 0, 0, 4'd0, 4'd0);
    step(0, 1, 1, 1, 4'd5, 4'd3);  hand(0, 0, 0, 0, 0, 0);

    // Unsynchronised: no checking whatever obs_count does
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 1'($urandom), 4'($urandom), 4'($urandom));
      hand(0, 0, 0, 0, 0, -1);
    end

    // obs_rst aligns, then a correct up-count through the wrap
    step(1, 1, 0, 1, 4'd0, 4'd7);  hand(1, 0, 0, 0, 0, 0);
    for (int i = 0; i <= 16; i++) begin
      step(1, 0, 0, 1, 4'd0, 4'(i % 16));
      hand(1, 0, 0, 0, 0, (i + 1) % 16);
    end

    // Load 1001, count down, then a single wrong value
    step(1, 0, 1, 0, 4'd9, 4'd1);  hand(1, 0, 0, 0, 0, 9);
    step(1, 0, 0, 0, 4'd0, 4'd9);  hand(1, 0, 0, 0, 0, 8);
    step(1, 0, 0, 0, 4'd0, 4'd8);  hand(1, 0, 0, 0, 0, 7);
    step(1, 0, 0, 0, 4'd0, 4'd7);  hand(1, 0, 0, 0, 0, 6);
    step(1, 0, 0, 0, 4'd0, 4'd0);  hand(1, 1, 1, 1, 1, RESYNC ? 15 : 5);
    step(1, 0, 1, 1, 4'd4, m_exp); hand(1, 0, 1, 1, 1, 4);

    // Fresh start, then a persistent +1 offset for three cycles
    step(0, 0, 0, 0, 4'd0, 4'd0);  hand(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 4'd4, 4'd0);  hand(1, 0, 0, 0, 0, 4);
    step(1, 0, 0, 1, 4'd0, 4'd5);  hand(1, 1, 1, 1, 1, RESYNC ? 6 : 5);
    step(1, 0, 0, 1, 4'd0, 4'd6);  hand(1, RESYNC ? 0 : 1, 1, RESYNC ? 1 : 2, RESYNC ? 1 : 2, RESYNC ? 7 : 6);
    step(1, 0, 0, 1, 4'd0, 4'd7);  hand(1, RESYNC ? 0 : 1, 1, RESYNC ? 1 : 3, RESYNC ? 1 : 3, RESYNC ? 8 : 7);
    c = RESYNC ? 1 : 3;

    // obs_rst and obs_load together: reset wins
    step(1, 1, 1, 1, 4'd5, m_exp); hand(1, 0, 1, c, c, 0);
    step(1, 0, 0, 1, 4'd0, 4'd0);  hand(1, 0, 1, c, c, 1);

    // Five mismatches: the ERRW=2 instance saturates at 3
    for (int k = 1; k <= 5; k++) begin
      step(1, 0, 0, 1, 4'd0, m_exp ^ 4'h8);
      hand(1, 1, 1, c + k, (c + k > 3) ? 3 : c + k, -1);
    end

    // Reset mid-TRACK clears everything; model then wraps 0000 down to 1111
    step(0, 1, 1, 1, 4'd5, 4'd2);  hand(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 4'd0, 4'd0);  hand(0, 0, 0, 0, 0, 15);

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
